audio_tone_gen: RTL and testbench
=================================

// Module: audio_tone_gen
// PURPOSE
//  Parametrised tone generator for the MIDI piano CPU.
//  - Takes the CPU key-port byte and picks one note by priority.
//  - Applies an octave shift to that note's half-period.
//  - Divides the system clock into a square wave audio_out that drives the buzzer/DAC pin.
//  - Note changes take effect only at the next toggle, so the output has no glitches.
//  - Exposes the active half-period and note index so the CPU can read back status.
// PARAMETERS
//  CNT_W     20  width of the half-period counter and of sol_rate (must be >= 17)
//  NUM_KEYS  8   number of port bits decoded (1..8); port bits >= NUM_KEYS are ignored
//  MIN_RATE  2   floor applied to the shifted half-period
// PORTS
//  clk       in   1          system clock, 50 MHz
//  reset     in   1          asynchronous, active-high reset
//  port      in   8          key bitmap from the CPU output port; bit0 = DO ... bit7 = DO'
//  octave    in   2          right-shift applied to the half-period (0 = base octave, 3 = +3 octaves)
//  audio_out out  1          square-wave tone
//  enable    out  1          1 while a tone is playing (state PLAY)
//  sol_rate  out  CNT_W      half-period currently in use, in clk cycles; 0 when idle
//  note_idx  out  3          index of the note currently playing; 0 when idle
// BEHAVIOUR
//  Reset (async, reset=1):
//   - state=IDLE; port_q, octave_q, cnt, audio_out, enable, sol_rate, note_idx all 0.
//  Input stage:
//   - port and octave are registered into port_q / octave_q every clk.
//  Decode (combinational from the registered values):
//   - idx = lowest set bit of port_q[NUM_KEYS-1:0].
//   - req_valid = 1 if any of those bits is set.
//  Base half-period table (50 MHz clock), by idx:
//   - 0..3: 95556, 85131, 75843, 71586
//   - 4..7: 63776, 56818, 50619, 47778
//  Requested rate:
//   - req_rate = max(table[idx] >> octave_q, MIN_RATE), truncated to CNT_W bits.
//  State machine IDLE:
//   - cnt=0, audio_out=0, enable=0, sol_rate=0, note_idx=0.
//   - On req_valid: go to PLAY; load sol_rate=req_rate, note_idx=idx, enable=1; cnt stays 0.
//   - Latency from a port change to enable=1 is 2 clk edges (input register + state register).
//  State machine PLAY:
//   - cnt increments each clk.
//   - At the terminal count (cnt == sol_rate-1), cnt<=0 and then:
//     - req_valid=1: audio_out toggles; sol_rate and note_idx reload from req_rate/idx.
//     - req_valid=0: audio_out<=0, enable<=0, sol_rate<=0, note_idx<=0; go to IDLE.
//   - Otherwise sol_rate, note_idx and audio_out hold.
//   - Each output half-period is exactly sol_rate cycles; the first high phase starts
//     sol_rate cycles after the IDLE->PLAY edge.
//  Glitch-free rule:
//   - A note/octave change or a release in mid-period never shortens or stretches the
//     current half-period.
//   - Port pulses shorter than the remaining half-period are ignored in PLAY.
//  Simultaneous keys:
//   - The lowest index wins; e.g. port=8'h24 plays idx 2.
//  Ignored combinations:
//   - port bits at or above NUM_KEYS: if only those are set, the port is treated as 0.
//  Reset mid-tone:
//   - Asserting reset in PLAY clears everything immediately, without waiting for a clk edge.
//   - After reset deasserts, restart follows the normal IDLE rule.
//  Width rule:
//   - The counter compare is CNT_W bits wide; the table values fit in 17 bits.
// TESTING
//  1. reset 1->0, port=8'h01, octave=0 -> enable=1 at the 2nd edge, sol_rate=95556,
//     audio_out toggles every 95556 cycles.
//  2. port=8'h28, octave=3 -> note_idx=3, sol_rate=8948 (71586>>3); period 17896 cycles.
//  3. Playing idx 0; switch port to 8'h80 at cnt=1000 -> current half ends at 95556;
//     the next half is 47778 cycles.
//  4. Playing; port=0 mid-period -> audio_out=0, enable=0, sol_rate=0 exactly at the
//     terminal count, not earlier.
//  5. NUM_KEYS=4, port=8'h10 -> stays IDLE, audio_out=0, sol_rate=0.
//  6. Playing with audio_out=1; pulse reset asynchronously between clk edges -> all outputs
//     are 0 before the next edge; restart after release is correct.

Source files
------------

// File: rtl/audio_tone_gen.sv
// Square-wave tone generator: picks the lowest pressed key, scales its half-period
// by the octave shift and toggles audio_out only on half-period boundaries.
module audio_tone_gen #(
    parameter int CNT_W    = 20,
    parameter int NUM_KEYS = 8,
    parameter int MIN_RATE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       port,
    input  logic [1:0]       octave,
    output logic             audio_out,
    output logic             enable,
    output logic [CNT_W-1:0] sol_rate,
    output logic [2:0]       note_idx
);

    typedef enum logic {IDLE, PLAY} state_t;

    localparam logic [7:0]  KEY_MASK  = 8'((1 << NUM_KEYS) - 1);
    localparam logic [16:0] MIN_RATE_W = 17'(MIN_RATE);

    state_t           state_q;
    logic [7:0]       port_q;
    logic [1:0]       octave_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] sol_rate_q;
    logic [2:0]       note_idx_q;
    logic             audio_q;
    logic             enable_q;

    logic [7:0]       keys;
    logic             req_valid_d;
    logic [2:0]       req_idx_d;
    logic [16:0]      shifted_d;
    logic [CNT_W-1:0] req_rate_d;
    logic             terminal;

    function automatic logic [16:0] base_half(input logic [2:0] i);
        case (i)
            3'd0:    return 17'd95556;
            3'd1:    return 17'd85131;
            3'd2:    return 17'd75843;
            3'd3:    return 17'd71586;
            3'd4:    return 17'd63776;
            3'd5:    return 17'd56818;
            3'd6:    return 17'd50619;
            default: return 17'd47778;
        endcase
    endfunction

    assign keys = port_q & KEY_MASK;

    // Scan from the top so the lowest set bit is the one left standing.
    always_comb begin
        req_idx_d   = 3'd0;
        req_valid_d = |keys;
        for (int i = 7; i >= 0; i--) begin
            if (keys[i]) begin
                req_idx_d = i[2:0];
            end
        end
        shifted_d  = base_half(req_idx_d) >> octave_q;
        req_rate_d = (shifted_d < MIN_RATE_W) ? CNT_W'(MIN_RATE_W) : CNT_W'(shifted_d);
    end

    assign terminal = (cnt_q == sol_rate_q - CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            port_q     <= '0;
            octave_q   <= '0;
            cnt_q      <= '0;
            sol_rate_q <= '0;
            note_idx_q <= '0;
            audio_q    <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            port_q   <= port;
            octave_q <= octave;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    audio_q <= 1'b0;
                    if (req_valid_d) begin
                        state_q    <= PLAY;
                        enable_q   <= 1'b1;
                        sol_rate_q <= req_rate_d;
                        note_idx_q <= req_idx_d;
                    end else begin
                        enable_q   <= 1'b0;
                        sol_rate_q <= '0;
                        note_idx_q <= '0;
                    end
                end
                PLAY: begin
                    // Requests are only sampled here, so mid-period changes never bend a half-period.
                    if (terminal) begin
                        cnt_q <= '0;
                        if (req_valid_d) begin
                            audio_q    <= ~audio_q;
                            sol_rate_q <= req_rate_d;
                            note_idx_q <= req_idx_d;
                        end else begin
                            state_q    <= IDLE;
                            audio_q    <= 1'b0;
                            enable_q   <= 1'b0;
                            sol_rate_q <= '0;
                            note_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign audio_out = audio_q;
    assign enable    = enable_q;
    assign sol_rate  = sol_rate_q;
    assign note_idx  = note_idx_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
// Bench for audio_tone_gen: decode table, directed timing sequences and a
// randomized run against a deadline-based reference model.
module tb_audio_tone_gen;

    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       port_r = 8'h01;
    logic [1:0]       oct_r = 2'd0;

    logic             a_out, en;
    logic [CNT_W-1:0] rate;
    logic [2:0]       nidx;
    logic             a_out4, en4;
    logic [CNT_W-1:0] rate4;
    logic [2:0]       nidx4;

    int checks = 0;
    int failures = 0;

    audio_tone_gen #(.CNT_W(CNT_W), .NUM_KEYS(8), .MIN_RATE(2)) dut (
        .clk(clk), .reset(rst), .port(port_r), .octave(oct_r),
        .audio_out(a_out), .enable(en), .sol_rate(rate), .note_idx(nidx)
    );

    audio_tone_gen #(.CNT_W(CNT_W), .NUM_KEYS(4), .MIN_RATE(2)) dut4 (
        .clk(clk), .reset(rst), .port(port_r), .octave(oct_r),
        .audio_out(a_out4), .enable(en4), .sol_rate(rate4), .note_idx(nidx4)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: half-period from the note table, shifted, floored at 2; 0 = no key.
    function automatic int ref_rate(input logic [7:0] p, input logic [1:0] o, input int nk);
        int base [8];
        int r;
        base = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};
        for (int i = 0; i < nk; i++) begin
            if (p[i]) begin
                r = base[i] >> o;
                return (r < 2) ? 2 : r;
            end
        end
        return 0;
    endfunction

    function automatic int ref_idx(input logic [7:0] p, input int nk);
        for (int i = 0; i < nk; i++) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    // Model tracks the cycle at which the current half-period ends, using the
    // key state as seen one edge earlier (input register).
    logic [7:0] h_port;
    logic [1:0] h_oct;
    longint     cyc, m_deadline;
    bit         m_play, m_out;
    int         m_rate, m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h_port <= 8'h00; h_oct <= 2'd0; cyc <= 0; m_deadline <= 0;
            m_play <= 0; m_out <= 0; m_rate <= 0; m_idx <= 0;
        end else begin
            cyc    <= cyc + 1;
            h_port <= port_r;
            h_oct  <= oct_r;
            if (!m_play) begin
                if (ref_rate(h_port, h_oct, 8) != 0) begin
                    m_play     <= 1;
                    m_out      <= 0;
                    m_rate     <= ref_rate(h_port, h_oct, 8);
                    m_idx      <= ref_idx(h_port, 8);
                    m_deadline <= cyc + ref_rate(h_port, h_oct, 8);
                end
            end else if (cyc == m_deadline) begin
                if (ref_rate(h_port, h_oct, 8) != 0) begin
                    m_out      <= !m_out;
                    m_rate     <= ref_rate(h_port, h_oct, 8);
                    m_idx      <= ref_idx(h_port, 8);
                    m_deadline <= cyc + ref_rate(h_port, h_oct, 8);
                end else begin
                    m_play <= 0; m_out <= 0; m_rate <= 0; m_idx <= 0;
                end
            end
        end
    end

    task automatic wait_level(input logic lvl, input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (a_out !== lvl && n < bound);
        if (a_out !== lvl) n = -1;
    endtask

    task automatic start_tone(input logic [7:0] p, input logic [1:0] o);
        int n;
        rst = 1'b1; port_r = p; oct_r = o;
        @(negedge clk); rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!en && n < 10);
        chk("start_latency", n, 2);
    endtask

    typedef struct packed {
        logic [7:0]  p;
        logic [1:0]  o;
        logic        en;
        logic [2:0]  idx;
        logic [19:0] rate;
        logic        en4;
        logic [19:0] rate4;
    } vec_t;

    vec_t vt [10];

    initial begin
        int n;
        int total, seg, hold, f0, sel;

        vt[0] = '{8'h01, 2'd0, 1'b1, 3'd0, 20'd95556, 1'b1, 20'd95556};
        vt[1] = '{8'h24, 2'd0, 1'b1, 3'd2, 20'd75843, 1'b1, 20'd75843};
        vt[2] = '{8'h28, 2'd3, 1'b1, 3'd3, 20'd8948,  1'b1, 20'd8948};
        vt[3] = '{8'h80, 2'd2, 1'b1, 3'd7, 20'd11944, 1'b0, 20'd0};
        vt[4] = '{8'h10, 2'd0, 1'b1, 3'd4, 20'd63776, 1'b0, 20'd0};
        vt[5] = '{8'h00, 2'd1, 1'b0, 3'd0, 20'd0,     1'b0, 20'd0};
        vt[6] = '{8'h60, 2'd1, 1'b1, 3'd5, 20'd28409, 1'b0, 20'd0};
        vt[7] = '{8'hF0, 2'd3, 1'b1, 3'd4, 20'd7972,  1'b0, 20'd0};
        vt[8] = '{8'h42, 2'd2, 1'b1, 3'd1, 20'd21282, 1'b1, 20'd21282};
        vt[9] = '{8'h08, 2'd1, 1'b1, 3'd3, 20'd35793, 1'b1, 20'd35793};

        // Reset state and base-octave start latency.
        #1;
        chk("rst_enable", int'(en), 0);
        chk("rst_audio", int'(a_out), 0);
        chk("rst_rate", int'(rate), 0);
        chk("rst_idx", int'(nidx), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("edge1_enable", int'(en), 0);
        @(posedge clk); #1;
        chk("edge2_enable", int'(en), 1);
        chk("edge2_rate", int'(rate), 95556);
        chk("edge2_audio", int'(a_out), 0);
        $display("txn start port=01 oct=0 enable=%0d sol_rate=%0d", en, rate);

        foreach (vt[i]) begin
            rst = 1'b1; port_r = vt[i].p; oct_r = vt[i].o;
            @(negedge clk); rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("vec_enable", int'(en), int'(vt[i].en));
            chk("vec_idx", int'(nidx), int'(vt[i].idx));
            chk("vec_rate", int'(rate), int'(vt[i].rate));
            chk("vec4_enable", int'(en4), int'(vt[i].en4));
            chk("vec4_rate", int'(rate4), int'(vt[i].rate4));
            $display("txn vec %0d port=%02h oct=%0d enable=%0d idx=%0d rate=%0d enable4=%0d rate4=%0d",
                     i, vt[i].p, vt[i].o, en, nidx, rate, en4, rate4);
        end

        // Full period at idx 3, octave 3.
        start_tone(8'h28, 2'd3);
        chk("t2_idx", int'(nidx), 3);
        wait_level(1'b1, 20000, n);
        chk("t2_first_half", n, 8948);
        wait_level(1'b0, 20000, n);
        chk("t2_second_half", n, 8948);
        $display("txn period port=28 oct=3 half=%0d", n);

        // Note change mid-period keeps the current half intact.
        start_tone(8'h01, 2'd3);
        repeat (1000) @(posedge clk);
        #1 port_r = 8'h80;
        wait_level(1'b1, 20000, n);
        chk("t3_rest_of_half", n, 11944 - 1000);
        chk("t3_new_rate", int'(rate), 5972);
        chk("t3_new_idx", int'(nidx), 7);
        wait_level(1'b0, 20000, n);
        chk("t3_next_half", n, 5972);
        $display("txn note_change 01->80 next_half=%0d", n);

        // Release mid-period: stays on until the terminal count.
        repeat (2000) @(posedge clk);
        #1 port_r = 8'h00;
        repeat (3971) @(posedge clk);
        #1;
        chk("t4_enable_before_end", int'(en), 1);
        chk("t4_rate_before_end", int'(rate), 5972);
        @(posedge clk); #1;
        chk("t4_enable_at_end", int'(en), 0);
        chk("t4_rate_at_end", int'(rate), 0);
        chk("t4_audio_at_end", int'(a_out), 0);
        chk("t4_idx_at_end", int'(nidx), 0);
        $display("txn release enable=%0d sol_rate=%0d", en, rate);

        // Asynchronous reset while audio is high.
        start_tone(8'h80, 2'd3);
        wait_level(1'b1, 20000, n);
        chk("t6_high_reached", n, 5972);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_audio", int'(a_out), 0);
        chk("t6_async_enable", int'(en), 0);
        chk("t6_async_rate", int'(rate), 0);
        chk("t6_async_idx", int'(nidx), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_restart_edge1", int'(en), 0);
        @(posedge clk); #1;
        chk("t6_restart_edge2", int'(en), 1);
        chk("t6_restart_rate", int'(rate), 5972);
        $display("txn async_reset restart enable=%0d rate=%0d", en, rate);

        // Randomized run against the reference model.
        rst = 1'b1; port_r = 8'h00; oct_r = 2'd3;
        @(negedge clk); rst = 1'b0;
        total = 0; seg = 0; f0 = failures;
        while (total < 30000 && failures - f0 < 20) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) port_r = 8'h00;
            else if (sel < 5) port_r = 8'(1 << $urandom_range(0, 7));
            else port_r = 8'($urandom);
            oct_r = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd3;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(50, 6000);
            $display("txn rnd seg=%0d port=%02h oct=%0d hold=%0d", seg, port_r, oct_r, hold);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("rnd_audio", int'(a_out), int'(m_out));
                chk("rnd_enable", int'(en), int'(m_play));
                chk("rnd_rate", int'(rate), m_rate);
                chk("rnd_idx", int'(nidx), m_idx);
                total++;
            end
            seg++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
